// File: rtl/iod_dly_responder.sv
// iod_dly_responder
// Responder end of the IOD bit-alignment control interface for one lane.
// Owns the delay-tap register and applies LOAD/MOVE commands from the
// training controller. Reports sticky EARLY/LATE/OOR flags back to the
// trainer. After every tap change it holds off for a settle window so that
// edge detects taken from unstable data are never reported.

module iod_dly_responder #(
    parameter int TAP_CNT_WIDTH    = 8,
    parameter int TAP_MAX          = 255,
    parameter int SETTLE_CNT_WIDTH = 3
) (
    input  logic                     SCLK,
    input  logic                     RESET,
    input  logic                     BIT_ALGN_LOAD,
    input  logic                     BIT_ALGN_MOVE,
    input  logic                     BIT_ALGN_DIR,
    input  logic                     BIT_ALGN_CLR_FLGS,
    input  logic                     EARLY_DET,
    input  logic                     LATE_DET,
    output logic                     IOD_EARLY,
    output logic                     IOD_LATE,
    output logic                     IOD_OOR,
    output logic [TAP_CNT_WIDTH-1:0] DLY_TAP,
    output logic                     DLY_UPDATE,
    output logic                     BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam logic [TAP_CNT_WIDTH-1:0]    TAP_MAX_V   = TAP_CNT_WIDTH'(TAP_MAX);
    localparam logic [TAP_CNT_WIDTH-1:0]    TAP_ONE     = TAP_CNT_WIDTH'(1);
    localparam logic [SETTLE_CNT_WIDTH-1:0] SETTLE_ONE  = SETTLE_CNT_WIDTH'(1);
    localparam logic [SETTLE_CNT_WIDTH-1:0] SETTLE_LAST = '1;

    state_t                      state_q, state_d;
    logic [TAP_CNT_WIDTH-1:0]    tap_q, tap_d;
    logic [SETTLE_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                        early_q, early_d;
    logic                        late_q, late_d;
    logic                        oor_q, oor_d;
    logic                        upd_q, upd_d;
    logic                        busy_q, busy_d;

    // Next-state logic: command decode in IDLE, settle timing, and sticky
    // flag handling. CLR_FLGS is applied last so it beats any flag set
    // in the same cycle, including an OOR raised by a simultaneous MOVE.
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        cnt_d   = cnt_q;
        early_d = early_q;
        late_d  = late_q;
        oor_d   = oor_q;

        case (state_q)
            ST_IDLE: begin
                early_d = early_q | EARLY_DET;
                late_d  = late_q | LATE_DET;
                if (BIT_ALGN_LOAD) begin
                    tap_d   = '0;
                    early_d = 1'b0;
                    late_d  = 1'b0;
                    oor_d   = 1'b0;
                    state_d = ST_APPLY;
                end else if (BIT_ALGN_MOVE) begin
                    if (BIT_ALGN_DIR) begin
                        if (tap_q >= TAP_MAX_V) begin
                            oor_d = 1'b1;
                        end else begin
                            tap_d   = tap_q + TAP_ONE;
                            state_d = ST_APPLY;
                        end
                    end else begin
                        if (tap_q == '0) begin
                            oor_d = 1'b1;
                        end else begin
                            tap_d   = tap_q - TAP_ONE;
                            state_d = ST_APPLY;
                        end
                    end
                end
            end
            ST_APPLY: begin
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + SETTLE_ONE;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (BIT_ALGN_CLR_FLGS) begin
            early_d = 1'b0;
            late_d  = 1'b0;
            oor_d   = 1'b0;
        end

        upd_d  = (state_d == ST_APPLY);
        busy_d = (state_d != ST_IDLE);
    end

    // State, tap, counter and every output are held in flops; reset returns
    // the block to IDLE and abandons any settle in progress.
    always_ff @(posedge SCLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            tap_q   <= '0;
            cnt_q   <= '0;
            early_q <= 1'b0;
            late_q  <= 1'b0;
            oor_q   <= 1'b0;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            cnt_q   <= cnt_d;
            early_q <= early_d;
            late_q  <= late_d;
            oor_q   <= oor_d;
            upd_q   <= upd_d;
            busy_q  <= busy_d;
        end
    end

    assign IOD_EARLY  = early_q;
    assign IOD_LATE   = late_q;
    assign IOD_OOR    = oor_q;
    assign DLY_TAP    = tap_q;
    assign DLY_UPDATE = upd_q;
    assign BUSY       = busy_q;

endmodule

// File: doc/iod_dly_responder.md
# iod_dly_responder

Responder end of the IOD bit-alignment control interface: it accepts LOAD/MOVE/DIR/CLR_FLGS commands from the receive bit-alignment training controller and owns the delay-tap register for one lane. It reports sticky EARLY/LATE/OOR flags back to the trainer. It sits between the training controller and the lane's programmable input delay cell and edge-detect logic. It enforces tap limits, a post-move settle window, and flag-clear semantics, so the trainer sees a well-behaved delay controller.

## Interface
Parameters:
- TAP_CNT_WIDTH, 8, width of tap register.
- TAP_MAX, 255, highest legal tap; must be ≤ 2^TAP_CNT_WIDTH−1.
- SETTLE_CNT_WIDTH, 3, settle window after any tap change is 2^SETTLE_CNT_WIDTH cycles.

Ports:
- SCLK  in  1  fabric clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- BIT_ALGN_LOAD  in  1  reset tap to 0 (level, sampled when idle).
- BIT_ALGN_MOVE  in  1  step tap by one (sampled when idle).
- BIT_ALGN_DIR  in  1  1 = increment, 0 = decrement; valid with MOVE.
- BIT_ALGN_CLR_FLGS  in  1  clear sticky EARLY/LATE/OOR.
- EARLY_DET  in  1  per-cycle early-edge detect from deserializer.
- LATE_DET  in  1  per-cycle late-edge detect from deserializer.
- IOD_EARLY  out  1  sticky early flag.
- IOD_LATE  out  1  sticky late flag.
- IOD_OOR  out  1  sticky out-of-range flag.
- DLY_TAP  out  TAP_CNT_WIDTH  current tap to delay cell.
- DLY_UPDATE  out  1  one-cycle strobe: DLY_TAP changed.
- BUSY  out  1  high during APPLY/SETTLE; commands ignored.

## Operation
- FSM states: IDLE, APPLY, SETTLE.
- IDLE, command priority: LOAD > MOVE. DIR is ignored without MOVE.
- LOAD in IDLE:
  - DLY_TAP ← 0.
  - EARLY/LATE/OOR ← 0.
  - Go to APPLY. This applies even if the tap is already 0.
- MOVE in IDLE:
  - DIR=1 with DLY_TAP=TAP_MAX, or DIR=0 with DLY_TAP=0:
    - Tap unchanged.
    - IOD_OOR ← 1.
    - Stay IDLE; no DLY_UPDATE, no BUSY.
  - Otherwise:
    - DLY_TAP ± 1. Arithmetic is unsigned, no wrap.
    - Go to APPLY.
- APPLY (1 cycle):
  - DLY_UPDATE=1.
  - Settle counter ← 0.
  - Go to SETTLE.
- SETTLE:
  - Counter increments each cycle.
  - Return to IDLE when counter = 2^SETTLE_CNT_WIDTH−1.
- Detect inputs:
  - EARLY_DET/LATE_DET set the sticky flags only in IDLE.
  - They are ignored in APPLY/SETTLE, because data is unstable after a tap change.
- Flag clearing:
  - CLR_FLGS clears all three flags in any state.
  - CLR_FLGS in the same cycle as a DET or OOR set: clear wins.
  - CLR_FLGS together with MOVE in IDLE: the move executes, flags end cleared, and an OOR caused by that move is also suppressed.
- MOVE/LOAD seen in APPLY/SETTLE are dropped, not queued. The trainer must wait for BUSY=0.
- RESET mid-operation: returns to IDLE immediately and all outputs go to reset values. Any pending settle is abandoned.

## Timing
- Reset values:
  - DLY_TAP=0.
  - IOD_EARLY=0, IOD_LATE=0, IOD_OOR=0.
  - DLY_UPDATE=0, BUSY=0.
  - State IDLE, counter 0.
- All outputs are registered.
- MOVE/LOAD sampled at edge n:
  - DLY_TAP new value and DLY_UPDATE=1 at n+1.
  - BUSY=1 from n+1 through n+1+2^SETTLE_CNT_WIDTH inclusive, i.e. 1+2^W cycles.
  - Next command accepted at edge n+2+2^W.
- Flags:
  - DET sampled at n in IDLE → flag high at n+1.
  - CLR_FLGS at n → flags low at n+1.
- OOR rejection: IOD_OOR high at n+1; BUSY stays 0.

## Test plan
- Reset, then 3× MOVE DIR=1, each issued after BUSY falls → DLY_TAP=3, three DLY_UPDATE strobes, BUSY width 9 cycles each (W=3).
- Tap at 0, MOVE DIR=0 → DLY_TAP stays 0, IOD_OOR=1 next cycle, no DLY_UPDATE. Then CLR_FLGS → IOD_OOR=0.
- Step tap to 255, MOVE DIR=1 → tap stays 255, IOD_OOR=1. Then LOAD → tap 0, OOR 0, DLY_UPDATE=1.
- EARLY_DET pulse during SETTLE → IOD_EARLY stays 0. Same pulse in IDLE → IOD_EARLY=1 until CLR_FLGS. CLR_FLGS and LATE_DET in same cycle → IOD_LATE=0.
- MOVE reasserted while BUSY=1 → ignored, tap changes only once. LOAD and MOVE together in IDLE → tap 0 (LOAD wins).
- RESET asserted mid-SETTLE with tap=40 → next cycle DLY_TAP=0, BUSY=0, all flags 0. MOVE then accepted immediately after reset deasserts.
